lc3_fetch_stage: RTL and testbench
==================================

// Module: lc3_fetch_stage
// PURPOSE
//  LC3 fetch stage: owns the PC, issues synchronous instruction-memory reads and
//  presents fetched instructions to decode. Drives the decode inputs: instr_dout,
//  npc_out, enable_decode. Sits between instruction memory and decode; acts as the
//  producer side of the decode-input handshake.
//  Also used standalone as an RTL stimulus source for decode-stage benches.
// PARAMETERS
//  PC_RESET   16'h3000  PC value loaded on reset
//  CNT_W      16        width of fetch_count
// PORTS
//  clock           in   1      rising-edge clock
//  reset_n         in   1      asynchronous, active-low reset
//  enable_fetch    in   1      issue an imem read this cycle
//  enable_updatePC in   1      advance or redirect PC at this edge
//  br_taken        in   1      with enable_updatePC: load taddr, flush in-flight read
//  taddr           in   16     branch/jump target
//  imem_rd         out  1      read strobe (combinational = enable_fetch)
//  imem_addr       out  16     read address (combinational = pc)
//  imem_dout       in   16     read data, valid the cycle after imem_rd
//  instr_dout      out  16     captured instruction to decode
//  npc_out         out  16     address of captured instruction + 1
//  enable_decode   out  1      1-cycle qualifier: instr_dout/npc_out are new
//  fetch_count     out  CNT_W  number of instructions delivered, wraps
// BEHAVIOUR
//  Reset (async assert, sync-edge release):
//   - pc=PC_RESET; state=IDLE; instr_dout=0; npc_out=0; enable_decode=0; fetch_count=0.
//   - Any read pending at reset assertion is discarded.
//  PC update at each edge, 16-bit modulo arithmetic:
//   - enable_updatePC&br_taken -> pc<=taddr
//   - enable_updatePC&!br_taken -> pc<=pc+1 (16'hFFFF wraps to 16'h0000)
//   - else pc holds (stall)
//  Read pipeline: latency 2 edges from imem_rd to enable_decode.
//   - Cycle N: enable_fetch=1 -> imem_rd=1, imem_addr=pc; edge: addr_q<=pc, state->PEND.
//   - Cycle N+1: imem_dout valid. At the edge: instr_dout<=imem_dout;
//     npc_out<=addr_q+1 (mod 2^16); enable_decode<=1; fetch_count++.
//   - enable_decode is 0 in any cycle not following a completed PEND capture.
//   - instr_dout/npc_out hold their values when no capture occurs.
//  State machine (IDLE, PEND):
//   - IDLE: enable_fetch -> PEND, else IDLE.
//   - PEND: capture as above; then enable_fetch -> PEND (back-to-back, 1 instr/cycle),
//     else IDLE.
//   - Dropping enable_fetch during PEND does not cancel the outstanding read; it
//     is still captured.
//  Flush: enable_updatePC&br_taken in a PEND cycle:
//   - In-flight data is discarded: no capture, enable_decode<=0, fetch_count holds.
//   - A read issued in that same cycle (address = pre-redirect pc) is also marked
//     flushed; its result is discarded.
//   - The first delivered instruction after a redirect has npc_out = taddr+1.
//  Stall (enable_fetch=1, enable_updatePC=0): same address re-read every cycle;
//   duplicate instr/npc delivered each cycle with enable_decode=1. Decode is
//   responsible for gating duplicates.
//  Simultaneous: pc update and read issue in one cycle use pre-update pc for
//   imem_addr.
//  fetch_count: wraps from 2^CNT_W-1 to 0 silently.
// TESTING
//  1. reset_n=0 mid-PEND -> all outputs 0 immediately, imem_addr=3000, and no
//     enable_decode after release.
//  2. fetch+updatePC=1 for 3 cycles; imem returns 1021,1422,5A81 ->
//     enable_decode on cycles 2-4; npc_out 3001,3002,3003; fetch_count=3.
//  3. Branch in PEND, taddr=3050 -> in-flight 3001 and redirect-cycle reads dropped;
//     next delivery has npc_out=3051.
//  4. Stall: updatePC=0, fetch=1 for 3 cycles at pc=3005 -> three deliveries,
//     each with npc_out=3006.
//  5. enable_fetch 1 for 1 cycle then 0 -> exactly one enable_decode pulse,
//     then state IDLE and outputs held.
//  6. pc=FFFF, fetch+update -> imem_addr FFFF then 0000; npc_out 0000 then 0001.

Source files
------------

// File: rtl/lc3_fetch_stage.sv
// LC3 fetch stage: owns the PC, issues synchronous imem reads and hands each
// captured instruction (with its next-PC) to decode behind a 1-cycle qualifier.
module lc3_fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_fetch,
    input  logic             enable_updatePC,
    input  logic             br_taken,
    input  logic [15:0]      taddr,
    output logic             imem_rd,
    output logic [15:0]      imem_addr,
    input  logic [15:0]      imem_dout,
    output logic [15:0]      instr_dout,
    output logic [15:0]      npc_out,
    output logic             enable_decode,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] addr_q;    // address of the read currently in flight
    logic        flush_q;   // in-flight read was issued in a redirect cycle
    logic        redirect;
    logic        capture;

    // Reads go out straight from the current (pre-update) PC.
    assign imem_rd   = enable_fetch;
    assign imem_addr = pc;
    assign redirect  = enable_updatePC & br_taken;

    // Next state and capture decision; a redirect kills the data arriving now.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: state_nxt = enable_fetch ? PEND : IDLE;
            PEND: begin
                capture   = !flush_q && !redirect;
                state_nxt = enable_fetch ? PEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC: redirect, advance, or hold; 16-bit wrap is natural.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pc <= PC_RESET;
        else if (enable_updatePC)
            pc <= br_taken ? taddr : pc + 16'd1;
    end

    // Read tracking: state, address of the issued read, and its flush mark.
    // A read launched alongside a redirect targets a stale PC, so it is
    // tagged here and dropped when its data returns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= 16'd0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= redirect;
            if (enable_fetch)
                addr_q <= pc;
        end
    end

    // Decode-side outputs: capture on a completed read, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_dout    <= 16'd0;
            npc_out       <= 16'd0;
            enable_decode <= 1'b0;
            fetch_count   <= '0;
        end else begin
            enable_decode <= capture;
            if (capture) begin
                instr_dout  <= imem_dout;
                npc_out     <= addr_q + 16'd1;
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Directed bench for lc3_fetch_stage with a queue scoreboard and a
// behavioural synchronous instruction memory.
module tb_lc3_fetch_stage;

    logic        clock;
    logic        reset_n;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        br_taken;
    logic [15:0] taddr;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_dout;
    logic [15:0] instr_dout;
    logic [15:0] npc_out;
    logic        enable_decode;
    logic [15:0] fetch_count;

    int passed = 0;
    int total  = 0;

    // model state
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    logic [15:0] m_instr;
    logic [15:0] m_npc;
    logic        last_issued;
    logic [31:0] q[$];   // {instr, npc} per issued, not-yet-delivered read

    lc3_fetch_stage #(.PC_RESET(16'h3000), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC),
        .br_taken(br_taken), .taddr(taddr),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .instr_dout(instr_dout), .npc_out(npc_out),
        .enable_decode(enable_decode), .fetch_count(fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h3000: memf = 16'h1021;
            16'h3001: memf = 16'h1422;
            16'h3002: memf = 16'h5A81;
            default:  memf = a ^ 16'hC3C3;
        endcase
    endfunction

    // synchronous memory: data for the address sampled at the edge
    logic [15:0] rd_q;
    always @(posedge clock) rd_q <= imem_addr;
    assign imem_dout = memf(rd_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 16'h3000; m_cnt = 16'd0; m_instr = 16'd0; m_npc = 16'd0;
        last_issued = 1'b0; q.delete();
    endtask

    // one clock with the given controls, driven from a negedge
    task automatic step(input logic f, input logic u, input logic b, input logic [15:0] t);
        logic        redir;
        logic        exp_dec;
        logic [31:0] e;
        enable_fetch = f; enable_updatePC = u; br_taken = b; taddr = t;
        #1;
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
        chk("imem_rd", {31'd0, imem_rd}, {31'd0, f});
        redir   = u & b;
        exp_dec = last_issued && !redir;
        if (last_issued && redir) void'(q.pop_back());
        last_issued = f && !redir;
        if (last_issued) q.push_back({memf(m_pc), m_pc + 16'd1});
        if (u) m_pc = b ? t : m_pc + 16'd1;
        @(posedge clock);
        @(negedge clock);
        chk("enable_decode", {31'd0, enable_decode}, {31'd0, exp_dec});
        if (exp_dec) begin
            e = q.pop_front();
            m_instr = e[31:16];
            m_npc   = e[15:0];
            m_cnt   = m_cnt + 16'd1;
        end
        chk("instr_dout", {16'd0, instr_dout}, {16'd0, m_instr});
        chk("npc_out", {16'd0, npc_out}, {16'd0, m_npc});
        chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        enable_fetch = 1'b0; enable_updatePC = 1'b0; br_taken = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; enable_fetch = 1'b0; enable_updatePC = 1'b0;
        br_taken = 1'b0; taddr = 16'd0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_instr", {16'd0, instr_dout}, 32'd0);
        chk("rst_npc", {16'd0, npc_out}, 32'd0);
        chk("rst_dec", {31'd0, enable_decode}, 32'd0);
        chk("rst_cnt", {16'd0, fetch_count}, 32'd0);
        chk("rst_addr", {16'd0, imem_addr}, 32'h3000);
        @(negedge clock);
        reset_n = 1'b1;

        // 1. reset mid-PEND after one delivery: outputs clear immediately
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        reset_n = 1'b0;
        #1;
        chk("t1_instr", {16'd0, instr_dout}, 32'd0);
        chk("t1_npc", {16'd0, npc_out}, 32'd0);
        chk("t1_dec", {31'd0, enable_decode}, 32'd0);
        chk("t1_cnt", {16'd0, fetch_count}, 32'd0);
        chk("t1_addr", {16'd0, imem_addr}, 32'h3000);
        enable_fetch = 1'b0; enable_updatePC = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);

        // 2. three back-to-back fetches
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("t2_cnt", {16'd0, fetch_count}, 32'd3);
        chk("t2_npc", {16'd0, npc_out}, 32'h3003);
        chk("t2_instr", {16'd0, instr_dout}, 32'h5A81);

        // 3. branch while 3001 is in flight
        do_reset();
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(1, 1, 1, 16'h3050);
        step(1, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("t3_npc", {16'd0, npc_out}, 32'h3051);

        // 4. stall at 3005: duplicate deliveries
        step(0, 1, 1, 16'h3005);
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("t4_npc", {16'd0, npc_out}, 32'h3006);

        // 5. single-cycle fetch then idle: one pulse, outputs held
        step(1, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);

        // 6. wrap at FFFF
        step(0, 1, 1, 16'hFFFF);
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        chk("t6_npc0", {16'd0, npc_out}, 32'h0000);
        step(0, 0, 0, 16'h0);
        chk("t6_npc1", {16'd0, npc_out}, 32'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // watchdog
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
